// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB register with stall/flush, result select and load extension (optional WB_RETIRE_CNT_EN retire counter)
module writeback_stage #(
  parameter int DATA_W = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ValidM,
  input  logic                  StallW,
  input  logic                  FlushW,
  input  logic                  RegWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic [2:0]            Funct3M,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [DATA_W-1:0]     ALU_ResultM,
  input  logic [DATA_W-1:0]     ReadDataM,
  input  logic [DATA_W-1:0]     PCPlus4M,
  input  logic [DATA_W-1:0]     ImmExtM,
  output logic                  RegWriteW,
  output logic [REG_ADDR_W-1:0] RdW,
  output logic [DATA_W-1:0]     ResultW,
  output logic                  ValidW
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]           RetireCnt
`endif
);
  localparam int OFF_W = $clog2(DATA_W / 8);
  logic                  valid_q, regwrite_q;
  logic [1:0]            src_q;
  logic [2:0]            funct3_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0]     alu_q, rdata_q, pc4_q, imm_q;
  logic [OFF_W-1:0]      off, half_off, word_off;
  logic [DATA_W-1:0]     byte_sh, half_sh, word_sh, load_ext;
  logic [7:0]            b;
  logic [15:0]           h;
  logic [31:0]           w;

  always_ff @(posedge clk)
    if (rst || FlushW) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      src_q      <= '0;
      funct3_q   <= '0;
      rd_q       <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
      pc4_q      <= '0;
      imm_q      <= '0;
    end else if (!StallW) begin
      valid_q    <= ValidM;
      regwrite_q <= RegWriteM;
      src_q      <= ResultSrcM;
      funct3_q   <= Funct3M;
      rd_q       <= RdM;
      alu_q      <= ALU_ResultM;
      rdata_q    <= ReadDataM;
      pc4_q      <= PCPlus4M;
      imm_q      <= ImmExtM;
    end

  // misaligned halves/words are truncated down to their natural lane
  assign off      = alu_q[OFF_W-1:0];
  assign half_off = off & ~OFF_W'(1);
  assign word_off = off & ~OFF_W'(3);
  assign byte_sh  = rdata_q >> {off, 3'b000};
  assign half_sh  = rdata_q >> {half_off, 3'b000};
  assign word_sh  = rdata_q >> {word_off, 3'b000};
  assign b = byte_sh[7:0];
  assign h = half_sh[15:0];
  assign w = word_sh[31:0];

  always_comb begin
    load_ext = rdata_q;
    case (funct3_q)
      3'b000: load_ext = DATA_W'($signed(b));
      3'b001: load_ext = DATA_W'($signed(h));
      3'b010: load_ext = (DATA_W == 32) ? rdata_q : DATA_W'($signed(w));
      3'b100: load_ext = DATA_W'(b);
      3'b101: load_ext = DATA_W'(h);
      3'b110: load_ext = (DATA_W == 32) ? rdata_q : DATA_W'(w);
      default: load_ext = rdata_q;
    endcase
  end

  assign ResultW   = src_q == 2'b00 ? alu_q :
                     src_q == 2'b01 ? load_ext :
                     src_q == 2'b10 ? pc4_q : imm_q;
  assign RegWriteW = valid_q & regwrite_q & (rd_q != '0);
  assign RdW       = rd_q;
  assign ValidW    = valid_q;

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk)
    if (rst) RetireCnt <= '0;
    else if (valid_q && !StallW) RetireCnt <= RetireCnt + 64'd1;
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed vectors against 32-bit and 64-bit writeback_stage instances
module tb_writeback_stage;
  logic clk = 1'b0, rst = 1'b1;
  logic valid_m = 1'b0, stall = 1'b0, flush = 1'b0, rw_m = 1'b0;
  logic [1:0] src_m = '0;
  logic [2:0] f3_m = '0;
  logic [4:0] rd_m = '0;
  logic [63:0] alu_m = '0, rdata_m = '0, pc4_m = '0, imm_m = '0;
  logic rw32, v32, rw64, v64;
  logic [4:0] rd32, rd64;
  logic [31:0] res32;
  logic [63:0] res64;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] cnt32, cnt64;
`endif
  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  writeback_stage #(.DATA_W(32)) dut32 (
    .clk(clk), .rst(rst), .ValidM(valid_m), .StallW(stall), .FlushW(flush),
    .RegWriteM(rw_m), .ResultSrcM(src_m), .Funct3M(f3_m), .RdM(rd_m),
    .ALU_ResultM(alu_m[31:0]), .ReadDataM(rdata_m[31:0]), .PCPlus4M(pc4_m[31:0]),
    .ImmExtM(imm_m[31:0]), .RegWriteW(rw32), .RdW(rd32), .ResultW(res32), .ValidW(v32)
`ifdef WB_RETIRE_CNT_EN
    , .RetireCnt(cnt32)
`endif
  );

  writeback_stage #(.DATA_W(64)) dut64 (
    .clk(clk), .rst(rst), .ValidM(valid_m), .StallW(stall), .FlushW(flush),
    .RegWriteM(rw_m), .ResultSrcM(src_m), .Funct3M(f3_m), .RdM(rd_m),
    .ALU_ResultM(alu_m), .ReadDataM(rdata_m), .PCPlus4M(pc4_m),
    .ImmExtM(imm_m), .RegWriteW(rw64), .RdW(rd64), .ResultW(res64), .ValidW(v64)
`ifdef WB_RETIRE_CNT_EN
    , .RetireCnt(cnt64)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] f3, input logic [63:0] alu, input logic [63:0] rd);
    valid_m = 1'b1; rw_m = 1'b1; rd_m = 5'd3; src_m = 2'b01;
    f3_m = f3; alu_m = alu; rdata_m = rd;
    step();
  endtask

  initial begin
    step(); step();
    check("rst_valid", 64'(v32), 64'd0);
    check("rst_rw", 64'(rw32), 64'd0);
    check("rst_rd", 64'(rd32), 64'd0);
    check("rst_res", 64'(res32), 64'd0);
    check("rst_res64", res64, 64'd0);
    rst = 1'b0;
    valid_m = 1'b1; rw_m = 1'b1; rd_m = 5'd5; src_m = 2'b00; alu_m = 64'h1234;
    step();
    check("alu_rw", 64'(rw32), 64'd1);
    check("alu_rd", 64'(rd32), 64'd5);
    check("alu_res", 64'(res32), 64'h1234);
    check("alu_valid", 64'(v32), 64'd1);
    load(3'b000, 64'h1001, 64'h80FF7F01);
    check("lb_off1", 64'(res32), 64'h7F);
    check("lb_off1_64", res64, 64'h7F);
    load(3'b000, 64'h1003, 64'h80FF7F01);
    check("lb_off3", 64'(res32), 64'hFFFFFF80);
    check("lb_off3_64", res64, 64'hFFFFFFFFFFFFFF80);
    load(3'b101, 64'h1002, 64'h80FF7F01);
    check("lhu_off2", 64'(res32), 64'h000080FF);
    load(3'b001, 64'h1003, 64'h80FF7F01);
    check("lh_misalign", 64'(res32), 64'hFFFF80FF);
    load(3'b100, 64'h1003, 64'h80FF7F01);
    check("lbu_off3", 64'(res32), 64'h80);
    load(3'b010, 64'h1002, 64'h80FF7F01);
    check("lw_32", 64'(res32), 64'h80FF7F01);
    load(3'b111, 64'h1001, 64'h80FF7F01);
    check("f3_other", 64'(res32), 64'h80FF7F01);
    load(3'b010, 64'h0, 64'hFFFFFFFF80000000);
    check("lw_64", res64, 64'hFFFFFFFF80000000);
    check("lw_32_low", 64'(res32), 64'h80000000);
    load(3'b110, 64'h0, 64'hFFFFFFFF80000000);
    check("lwu_64", res64, 64'h0000000080000000);
    check("lwu_32_pass", 64'(res32), 64'h80000000);
    load(3'b011, 64'h0, 64'hFFFFFFFF80000000);
    check("ld_64", res64, 64'hFFFFFFFF80000000);
    load(3'b010, 64'h6, 64'h8000000000000001);
    check("lw_64_hi", res64, 64'hFFFFFFFF80000000);
    load(3'b110, 64'h6, 64'h8000000000000001);
    check("lwu_64_hi", res64, 64'h0000000080000000);
    rd_m = 5'd0; src_m = 2'b00; alu_m = 64'h99;
    step();
    check("x0_rw", 64'(rw32), 64'd0);
    rd_m = 5'd6; src_m = 2'b10; pc4_m = 64'h44;
    step();
    check("pc4_res", 64'(res32), 64'h44);
    check("pc4_rw", 64'(rw32), 64'd1);
    src_m = 2'b11; imm_m = 64'hABCDE000;
    step();
    check("imm_res", 64'(res32), 64'hABCDE000);
    valid_m = 1'b0;
    step();
    check("inval_rw", 64'(rw32), 64'd0);
    check("inval_valid", 64'(v32), 64'd0);
    check("inval_res", 64'(res32), 64'hABCDE000);
    valid_m = 1'b1; rw_m = 1'b1; rd_m = 5'd7; src_m = 2'b00; alu_m = 64'hA5A5;
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd_m = 5'(9 + i); alu_m = 64'(32'h5555 + i); valid_m = 1'b0;
      step();
      check("stall_rd", 64'(rd32), 64'd7);
      check("stall_res", 64'(res32), 64'hA5A5);
      check("stall_valid", 64'(v32), 64'd1);
    end
    flush = 1'b1;
    step();
    check("flush_valid", 64'(v32), 64'd0);
    check("flush_rw", 64'(rw32), 64'd0);
    check("flush_res", 64'(res32), 64'd0);
    stall = 1'b0; flush = 1'b0;
    valid_m = 1'b1; rd_m = 5'd8; alu_m = 64'h77;
    step();
    stall = 1'b1; rst = 1'b1;
    step();
    check("rst_stall_valid", 64'(v32), 64'd0);
    check("rst_stall_rd", 64'(rd32), 64'd0);
    stall = 1'b0;
`ifdef WB_RETIRE_CNT_EN
    step();
    check("cnt_rst", cnt32, 64'd0);
    rst = 1'b0; valid_m = 1'b1;
    step(); step();
    stall = 1'b1; step();
    stall = 1'b0; flush = 1'b1; step();
    flush = 1'b0; step(); step();
    valid_m = 1'b0; step(); step();
    check("cnt_four", cnt32, 64'd4);
    check("cnt_four_64", cnt64, 64'd4);
    rst = 1'b1; step();
    check("cnt_clear", cnt32, 64'd0);
    rst = 1'b0;
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Parametrised successor to the single-mux writeback path. Adds the MEM/WB pipeline register and stall/flush control.
- Selects among four result sources and performs load-data byte/half/word extraction with sign or zero extension.
- Gates the register-file write strobe with a valid bit. Exposes the registered result for the forwarding unit.
- Sits between the memory cycle and the register file / hazard unit.

Parameters:
DATA_W, 32, datapath width; legal values are 32 or 64
REG_ADDR_W, 5, register index width
OFF_W, derived, log2(DATA_W/8); 2 for 32-bit, 3 for 64-bit

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
ValidM  input  1  the memory-stage instruction is valid
StallW  input  1  hold the stage register
FlushW  input  1  invalidate the stage register
RegWriteM  input  1  the instruction writes rd
ResultSrcM  input  2  result select: 00 ALU, 01 load, 10 PC+4, 11 immediate
Funct3M  input  3  load size and sign
RdM  input  REG_ADDR_W  destination register
ALU_ResultM  input  DATA_W  ALU result; its low OFF_W bits are the byte offset
ReadDataM  input  DATA_W  raw memory read word
PCPlus4M  input  DATA_W  PC+4
ImmExtM  input  DATA_W  immediate (LUI path)
RegWriteW  output  1  register-file write enable
RdW  output  REG_ADDR_W  register-file write index
ResultW  output  DATA_W  register-file write data; also drives the forwarding path
ValidW  output  1  the stage holds a valid instruction

Behaviour:
- Reset: all stage registers clear. ValidW=0, RegWriteW=0, RdW=0, ResultW=0.
- Stage register update, in priority order each rising clk:
  - rst: clear all registers.
  - else FlushW: ValidW<=0, all other fields <=0. Flush beats stall.
  - else StallW: hold all registers.
  - else: capture every M input; ValidW<=ValidM.
- Latency: an M-side value appears on the W outputs one cycle after capture. Output logic is combinational from the registered fields only.
- RegWriteW = ValidW & RegWrite_q & (Rd_q != 0). Writes to x0 are suppressed.
- Result select (registered fields): 00 ALU_Result_q, 01 load_ext, 10 PCPlus4_q, 11 ImmExt_q.
- Load extraction uses off = ALU_Result_q[OFF_W-1:0].
  - Byte lane: ReadData_q >> (off*8).
  - Half lane: ReadData_q >> (off with bit0 cleared)*8. Misaligned offsets are truncated, never trapped.
  - Word lane (64-bit only): ReadData_q >> (off with bits[1:0] cleared)*8.
- Load result by Funct3:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: full word when DATA_W=32; sign-extended word lane when DATA_W=64.
  - 011 LD: full doubleword (64-bit only).
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - 110 LWU: zero-extended word lane (64-bit only).
  - Any other code: pass ReadData_q unchanged.
- ResultW is valid even when ValidW=0, since the forwarding unit qualifies it with RegWriteW.
- Reset mid-stall: reset wins and clears all registers.
- A stall of any length holds the outputs stable.

Optional Feature:
Macro WB_RETIRE_CNT_EN.
- Defined:
  - Adds output RetireCnt, 64 bits.
  - Increments by 1 on every clk where ValidW=1 and the stage advances (StallW=0).
  - Cleared by rst. Not cleared by FlushW. Wraps from all-ones to 0.
- Undefined: no counter, no port, and no logic difference otherwise.

Test Plan:
- Reset, then ValidM=1, RegWriteM=1, RdM=5, ResultSrcM=00, ALU_ResultM=0x1234 -> one cycle later RegWriteW=1, RdW=5, ResultW=0x00001234.
- Load select, ReadDataM=0x80FF7F01, ALU_ResultM=0x1001, Funct3M=000 -> ResultW=0x0000007F. Same with ALU_ResultM=0x1003 -> 0xFFFFFF80. Funct3M=101 with ALU_ResultM=0x1002 -> 0x000080FF.
- RdM=0 with RegWriteM=1 -> RegWriteW=0. ResultSrcM=10, PCPlus4M=0x44 -> ResultW=0x44.
- Load valid instruction A, then assert StallW for 3 cycles while M inputs change -> W outputs stay equal to A. Assert StallW and FlushW together -> next cycle ValidW=0, RegWriteW=0.
- DATA_W=64, ReadDataM=0xFFFFFFFF80000000, ALU_ResultM offset 0, Funct3M=010 -> ResultW=0xFFFFFFFF80000000. Funct3M=110 -> 0x0000000080000000.
- WB_RETIRE_CNT_EN defined: 4 valid instructions with one stall cycle and one flushed bubble -> RetireCnt=4. After rst -> RetireCnt=0.
